// File: rtl/systolic_sequencer.sv
// Sequencer for a max_dim x max_dim systolic array: captures A/B on start, feeds
// them with the diagonal skew, drains the pipeline and waits for the array to finish.
module systolic_sequencer #(
  parameter int data_width     = 32,
  parameter int bus_width      = 64,
  parameter int timeout_cycles = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mode_in,
  input  logic [(bus_width/data_width)*(bus_width/data_width)*data_width-1:0] mat_a,
  input  logic [(bus_width/data_width)*(bus_width/data_width)*data_width-1:0] mat_b,
  input  logic calc_done_in,
  output logic [(bus_width/data_width)*data_width-1:0] a_feed,
  output logic [(bus_width/data_width)*data_width-1:0] b_feed,
  output logic start_bit_o,
  output logic done_padding_o,
  output logic mode_bit_o,
  output logic busy,
  output logic done,
  output logic timeout_err
);

  localparam int max_dim  = bus_width / data_width;
  localparam int mat_w    = max_dim * max_dim * data_width;
  localparam int row_w    = max_dim * data_width;
  localparam int feed_len = 2 * max_dim - 1;
  localparam int tw       = $clog2(2 * max_dim + 1);
  localparam int ww       = $clog2(timeout_cycles + 1);

  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, WAIT, FIN} state_t;

  state_t           state;
  logic [mat_w-1:0] a_reg;
  logic [mat_w-1:0] b_reg;
  logic [tw-1:0]    t;
  logic [ww-1:0]    wait_cnt;
  logic [tw-1:0]    feed_idx;
  logic [row_w-1:0] a_sched;
  logic [row_w-1:0] b_sched;

  // Feed outputs are registered, so the schedule is built for the step being entered.
  assign feed_idx = (state == LOAD) ? '0 : t + tw'(1);

  always_comb begin
    a_sched = '0;
    b_sched = '0;
    for (int i = 0; i < max_dim; i++) begin
      for (int k = 0; k < max_dim; k++) begin
        if (int'(feed_idx) == i + k) begin
          a_sched[i*data_width +: data_width] = a_reg[(i*max_dim + k)*data_width +: data_width];
          b_sched[i*data_width +: data_width] = b_reg[(k*max_dim + i)*data_width +: data_width];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      t              <= '0;
      wait_cnt       <= '0;
      a_feed         <= '0;
      b_feed         <= '0;
      start_bit_o    <= 1'b0;
      done_padding_o <= 1'b0;
      mode_bit_o     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg       <= mat_a;
            b_reg       <= mat_b;
            mode_bit_o  <= mode_in;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          t              <= '0;
          a_feed         <= a_sched;
          b_feed         <= b_sched;
          start_bit_o    <= 1'b1;
          done_padding_o <= 1'b1;
          state          <= FEED;
        end
        FEED: begin
          if (t == tw'(feed_len - 1)) begin
            t      <= '0;
            a_feed <= '0;
            b_feed <= '0;
            state  <= DRAIN;
          end else begin
            t      <= t + tw'(1);
            a_feed <= a_sched;
            b_feed <= b_sched;
          end
        end
        DRAIN: begin
          if (t == tw'(max_dim - 1)) begin
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            t <= t + tw'(1);
          end
        end
        WAIT: begin
          // Completion takes priority over a timeout reached in the same cycle.
          if (calc_done_in || (wait_cnt == ww'(timeout_cycles - 1))) begin
            if (!calc_done_in) timeout_err <= 1'b1;
            start_bit_o    <= 1'b0;
            done_padding_o <= 1'b0;
            done           <= 1'b1;
            state          <= FIN;
          end else begin
            wait_cnt <= wait_cnt + ww'(1);
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench for systolic_sequencer: directed literal run, table of
// runs checked cycle by cycle through a scoreboard queue, reset and idle corners.
module tb_systolic_sequencer;

  localparam int DW = 32;
  localparam int BW = 64;
  localparam int TO = 16;
  localparam int MD = BW / DW;
  localparam int MW = MD * MD * DW;
  localparam int RW = MD * DW;
  localparam int WAIT_START = 3 * MD + 1;
  localparam int NVEC = 5;

  typedef struct {
    logic [MW-1:0] mat_a;
    logic [MW-1:0] mat_b;
    logic          mode;
    int            done_wait;
    bit            perturb;
  } vec_t;

  typedef struct {
    logic          busy;
    logic          strt;
    logic          done;
    logic          tmo;
    logic          mode;
    logic [RW-1:0] a;
    logic [RW-1:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic mode_in = 1'b0;
  logic calc_done_in = 1'b0;
  logic [MW-1:0] mat_a = '0;
  logic [MW-1:0] mat_b = '0;
  logic [RW-1:0] a_feed;
  logic [RW-1:0] b_feed;
  logic start_bit_o, done_padding_o, mode_bit_o, busy, done, timeout_err;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  vec_t vecs[NVEC];

  systolic_sequencer #(.data_width(DW), .bus_width(BW), .timeout_cycles(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in),
    .mat_a(mat_a), .mat_b(mat_b), .calc_done_in(calc_done_in),
    .a_feed(a_feed), .b_feed(b_feed), .start_bit_o(start_bit_o),
    .done_padding_o(done_padding_o), .mode_bit_o(mode_bit_o),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [255:0] pack_out();
    return 256'({busy, start_bit_o, done_padding_o, done, timeout_err, mode_bit_o, a_feed, b_feed});
  endfunction

  function automatic logic [255:0] pack_exp(input exp_t e);
    return 256'({e.busy, e.strt, e.strt, e.done, e.tmo, e.mode, e.a, e.b});
  endfunction

  // Reference timing: LOAD at cycle 1, FEED 2..2*MD, DRAIN next MD cycles, then WAIT.
  task automatic build_expected(input vec_t v);
    exp_t e;
    int fin;
    int t;
    fin = WAIT_START + ((v.done_wait < 0) ? TO : v.done_wait + 1);
    for (int c = 1; c <= fin + 1; c++) begin
      e.busy = (c <= fin);
      e.strt = (c >= 2 && c < fin);
      e.done = (c == fin);
      e.tmo  = (v.done_wait < 0) && (c >= fin);
      e.mode = v.mode;
      e.a = '0;
      e.b = '0;
      if (c >= 2 && c <= 2 * MD) begin
        t = c - 2;
        for (int i = 0; i < MD; i++) begin
          if (t - i >= 0 && t - i < MD) begin
            e.a[i*DW +: DW] = v.mat_a[(i*MD + (t - i))*DW +: DW];
            e.b[i*DW +: DW] = v.mat_b[((t - i)*MD + i)*DW +: DW];
          end
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    exp_t e;
    int n;
    mat_a = v.mat_a;
    mat_b = v.mat_b;
    mode_in = v.mode;
    start = 1'b1;
    calc_done_in = 1'b0;
    build_expected(v);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_output($sformatf("vec%0d_cycle%0d", idx, c), pack_out(), pack_exp(e));
      start = v.perturb && (c == 3);
      if (v.perturb && c == 3) begin
        mat_a = ~v.mat_a;
        mode_in = ~v.mode;
      end
      calc_done_in = (v.perturb && c == 3) || (v.done_wait >= 0 && c == WAIT_START + v.done_wait);
    end
    start = 1'b0;
    calc_done_in = 1'b0;
  endtask

  initial begin
    logic [63:0] lit_a [0:4];
    logic [63:0] lit_b [0:4];

    vecs[0] = '{mat_a: {32'd4, 32'd3, 32'd2, 32'd1}, mat_b: {32'd8, 32'd7, 32'd6, 32'd5},
                mode: 1'b1, done_wait: 2, perturb: 1'b0};
    vecs[1] = '{mat_a: {32'hdeadbeef, 32'h12345678, 32'h0badf00d, 32'hcafef00d},
                mat_b: {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
                mode: 1'b0, done_wait: -1, perturb: 1'b0};
    vecs[2] = '{mat_a: {32'd40, 32'd30, 32'd20, 32'd10},
                mat_b: {32'hffffffff, 32'h00000001, 32'h80000000, 32'h7fffffff},
                mode: 1'b1, done_wait: 0, perturb: 1'b1};
    vecs[3] = '{mat_a: {32'ha5a5a5a5, 32'h5a5a5a5a, 32'h00ff00ff, 32'hff00ff00},
                mat_b: {32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10},
                mode: 1'b0, done_wait: TO - 1, perturb: 1'b0};
    vecs[4] = '{mat_a: {32'd7, 32'd0, 32'd9, 32'd3}, mat_b: {32'd2, 32'd11, 32'd0, 32'd6},
                mode: 1'b1, done_wait: TO - 2, perturb: 1'b0};

    lit_a = '{64'h00000000_00000001, 64'h00000003_00000002, 64'h00000004_00000000, 64'h0, 64'h0};
    lit_b = '{64'h00000000_00000005, 64'h00000006_00000007, 64'h00000008_00000000, 64'h0, 64'h0};

    #1 reset = 1'b0;
    #1 check_output("reset_outputs", pack_out(), 256'(0));
    @(negedge clk);
    reset = 1'b1;

    // Directed run with literal expectations for the 2x2 example.
    mat_a = {32'd4, 32'd3, 32'd2, 32'd1};
    mat_b = {32'd8, 32'd7, 32'd6, 32'd5};
    mode_in = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 6) begin
        check_output($sformatf("lit_a_feed_c%0d", c), 256'(a_feed), 256'(lit_a[c-2]));
        check_output($sformatf("lit_b_feed_c%0d", c), 256'(b_feed), 256'(lit_b[c-2]));
      end
      check_output($sformatf("lit_pad_c%0d", c), 256'({start_bit_o, done_padding_o}),
                   (c >= 2 && c <= 9) ? 256'(2'b11) : 256'(0));
      check_output($sformatf("lit_done_c%0d", c), 256'(done), 256'(c == 10));
      check_output($sformatf("lit_busy_c%0d", c), 256'(busy), 256'(c <= 10));
      start = 1'b0;
      calc_done_in = (c == 9);
    end
    calc_done_in = 1'b0;

    for (int v = 0; v < NVEC; v++) apply_stimulus(vecs[v], v);

    // Reset in the middle of DRAIN.
    mat_a = vecs[3].mat_a;
    mat_b = vecs[3].mat_b;
    mode_in = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_output("busy_before_reset", 256'({busy, start_bit_o, mode_bit_o}), 256'(3'b111));
    reset = 1'b0;
    #1 check_output("reset_mid_run", pack_out(), 256'(0));
    repeat (2) @(negedge clk);
    check_output("reset_held", pack_out(), 256'(0));
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output($sformatf("post_reset_idle%0d", c), 256'({busy, done, start_bit_o}), 256'(0));
    end

    // calc_done_in in IDLE must be ignored.
    calc_done_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output($sformatf("idle_calc_done%0d", c), 256'({busy, done, start_bit_o}), 256'(0));
    end
    calc_done_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 Parameter data_width, default 32, element width in bits.
REQ-002 Parameter bus_width, default 64, accumulator width in bits; max_dim = bus_width/data_width is a localparam (2 by default).
REQ-003 Parameter timeout_cycles, default 16, maximum WAIT cycles before error.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to run one matrix product.
REQ-007 mode_in  input  1  operating mode forwarded to the array.
REQ-008 mat_a  input  max_dim*max_dim*data_width  matrix A, row-major; element (r,c) at slice index r*max_dim+c.
REQ-009 mat_b  input  max_dim*max_dim*data_width  matrix B, same layout as mat_a.
REQ-010 calc_done_in  input  1  finish indication from the systolic array.
REQ-011 a_feed  output  max_dim*data_width  skewed A row inputs; slice i feeds array row i.
REQ-012 b_feed  output  max_dim*data_width  skewed B column inputs; slice j feeds array column j.
REQ-013 start_bit_o  output  1  array start level.
REQ-014 done_padding_o  output  1  array padding-complete level.
REQ-015 mode_bit_o  output  1  latched mode.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 timeout_err  output  1  sticky timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, FEED, DRAIN, WAIT, FIN.
REQ-020 IDLE->LOAD when start=1; start SHALL be ignored in every other state.
REQ-021 On start acceptance, mat_a, mat_b and mode_in SHALL be captured into internal registers; later input changes SHALL have no effect on the run.
REQ-022 LOAD SHALL last 1 cycle and clear the feed counter t to 0, then go to FEED.
REQ-023 FEED SHALL last exactly 2*max_dim-1 cycles (t=0..2*max_dim-2), then go to DRAIN.
REQ-024 During FEED, a_feed slice i SHALL equal A[i][t-i] when 0<=t-i<max_dim, else 0.
REQ-025 During FEED, b_feed slice j SHALL equal B[t-j][j] when 0<=t-j<max_dim, else 0.
REQ-026 DRAIN SHALL last max_dim cycles with a_feed=b_feed=0, then go to WAIT.
REQ-027 In all states except FEED, a_feed and b_feed SHALL be 0.
REQ-028 start_bit_o and done_padding_o SHALL be registered and high from the first FEED cycle through the last WAIT cycle inclusive.
REQ-029 mode_bit_o SHALL hold the captured mode from LOAD until the next accepted start.
REQ-030 WAIT->FIN on calc_done_in=1; calc_done_in in any other state SHALL be ignored.
REQ-031 WAIT SHALL count cycles; on reaching timeout_cycles without calc_done_in, it SHALL set timeout_err and go to FIN.
REQ-032 If calc_done_in=1 in the same cycle the timeout count is reached, completion SHALL win and timeout_err SHALL stay unchanged.
REQ-033 FIN SHALL assert done for exactly 1 cycle, then return to IDLE; a new start SHALL be acceptable on the cycle after FIN.
REQ-034 timeout_err SHALL be cleared only by reset or by the next accepted start.
REQ-035 All counters SHALL be sized for their maximum value plus 1, and SHALL NOT wrap within a run.

Reset
REQ-036 While reset=0, state=IDLE and all outputs and internal registers SHALL be 0, asynchronously.
REQ-037 Reset asserted mid-run SHALL abort the run with no done pulse.
REQ-038 After reset deasserts, the block SHALL require a fresh start.

Verification
REQ-039 max_dim=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start at cycle 0 -> LOAD at cycle 1; FEED cycles 2-4 with a_feed (row0,row1) = (1,0),(2,3),(0,4) and b_feed (col0,col1) = (5,0),(7,6),(0,8); zeros on cycles 5-6; WAIT from cycle 7.
REQ-040 calc_done_in pulsed at cycle 9 -> FIN at cycle 10 with done=1 for one cycle; busy=0 at cycle 11; start_bit_o and done_padding_o high for cycles 2-9.
REQ-041 calc_done_in held 0 -> timeout_err=1 and a done pulse 16 WAIT cycles after WAIT entry; the next start clears timeout_err.
REQ-042 start re-pulsed during FEED and mat_a changed mid-run -> no restart, and the feed values match the originally captured matrices.
REQ-043 reset driven low during DRAIN -> all outputs 0 immediately; no done pulse; IDLE after release.
REQ-044 calc_done_in=1 in IDLE or FEED -> no state change and no done pulse.
